// File: rtl/cci_read_scheduler.sv
// cci_read_scheduler: round-robin arbiter sharing the CCI TX0 read channel
// among NUM_REQ requesters, with per-requester outstanding-read credits,
// index tagging of mdata and RX0 response routing back to the owner.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   afu_en           low blocks new grants and parks the priority pointer at 0
//   req_valid/addr   per-requester read requests (slice i of req_addr is requester i)
//   req_grant        combinational one-hot grant, request consumed this cycle
//   tx_almostfull    TX0 back-pressure, no grant while high
//   tx_rdvalid/addr/mdata  registered TX0 read request, mdata = {0, index}
//   rx_rdvalid/mdata RX0 read response and its tag
//   rsp_valid        registered one-hot response strobe to the owning requester
//   idle             all outstanding counters zero (combinational)
//   err_tag          sticky bad-tag / response-underflow flag
module cci_read_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MDATA_W = 13,
   parameter int unsigned MAX_OUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      afu_en,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_grant,
   input  logic                      tx_almostfull,
   output logic                      tx_rdvalid,
   output logic [ADDR_W-1:0]         tx_addr,
   output logic [MDATA_W-1:0]        tx_mdata,
   input  logic                      rx_rdvalid,
   input  logic [MDATA_W-1:0]        rx_mdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      idle,
   output logic                      err_tag
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic [IDX_W-1:0]  rx_idx;
   logic              rx_bad;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] dec;
   logic [ADDR_W-1:0] gnt_addr;
   logic              underflow;
   logic [CNT_W-1:0]  cnt     [NUM_REQ];
   logic [CNT_W-1:0]  cnt_nxt [NUM_REQ];

   // Only the low index bits of the tag carry routing information.
   assign rx_idx = rx_mdata[IDX_W-1:0];
   assign rx_bad = 32'(rx_idx) >= NUM_REQ;

   // Per-requester eligibility: pending, under credit limit, channel open.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = req_valid[i] && (32'(cnt[i]) < MAX_OUT) && afu_en && !tx_almostfull;
   end

   // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      req_grant = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'((32'(ptr) + 32'(off)) % NUM_REQ);
         if (!gnt_any && elig[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any)
         req_grant[gnt_idx] = 1'b1;
   end

   // Address mux for the granted requester.
   always_comb begin
      gnt_addr = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_grant[i])
            gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
   end

   // Response decode; a bad tag matches no requester.
   always_comb begin
      dec = '0;
      for (int i = 0; i < NUM_REQ; i++)
         dec[i] = rx_rdvalid && !rx_bad && (rx_idx == IDX_W'(i));
   end

   // Credit counters: grant and response in the same cycle cancel out.
   always_comb begin
      underflow = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt_nxt[i] = cnt[i];
         if (req_grant[i] && !dec[i])
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         else if (dec[i] && !req_grant[i]) begin
            if (cnt[i] == '0)
               underflow = 1'b1;
            else
               cnt_nxt[i] = cnt[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      idle = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
         if (cnt[i] != '0)
            idle = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr        <= '0;
         tx_rdvalid <= 1'b0;
         tx_addr    <= '0;
         tx_mdata   <= '0;
         rsp_valid  <= '0;
         err_tag    <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else begin
         tx_rdvalid <= gnt_any;
         if (gnt_any) begin
            tx_addr  <= gnt_addr;
            tx_mdata <= MDATA_W'(gnt_idx);
         end
         if (!afu_en)
            ptr <= '0;
         else if (gnt_any)
            ptr <= IDX_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
         rsp_valid <= dec;
         if ((rx_rdvalid && rx_bad) || underflow)
            err_tag <= 1'b1;
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_cci_read_scheduler.sv
// Bench for cci_read_scheduler: a 2-requester instance with MAX_OUT=4 driven
// from a vector table, plus a 3-requester instance for wrap and bad-tag cases.
module tb_cci_read_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   // Instance A: NUM_REQ=2, MAX_OUT=4
   logic        afu_en;
   logic [1:0]  req_valid;
   logic [63:0] req_addr;
   logic [1:0]  req_grant;
   logic        tx_almostfull;
   logic        tx_rdvalid;
   logic [31:0] tx_addr;
   logic [12:0] tx_mdata;
   logic        rx_rdvalid;
   logic [12:0] rx_mdata;
   logic [1:0]  rsp_valid;
   logic        idle;
   logic        err_tag;

   cci_read_scheduler #(.NUM_REQ(2), .ADDR_W(32), .MDATA_W(13), .MAX_OUT(4)) dut_a (
      .clk(clk), .reset(reset), .afu_en(afu_en),
      .req_valid(req_valid), .req_addr(req_addr), .req_grant(req_grant),
      .tx_almostfull(tx_almostfull), .tx_rdvalid(tx_rdvalid),
      .tx_addr(tx_addr), .tx_mdata(tx_mdata),
      .rx_rdvalid(rx_rdvalid), .rx_mdata(rx_mdata),
      .rsp_valid(rsp_valid), .idle(idle), .err_tag(err_tag)
   );

   // Instance B: NUM_REQ=3, MAX_OUT=2
   logic [2:0]  b_req_valid;
   logic [95:0] b_req_addr;
   logic [2:0]  b_req_grant;
   logic        b_tx_rdvalid;
   logic [31:0] b_tx_addr;
   logic [12:0] b_tx_mdata;
   logic        b_rx_rdvalid;
   logic [12:0] b_rx_mdata;
   logic [2:0]  b_rsp_valid;
   logic        b_idle;
   logic        b_err_tag;

   cci_read_scheduler #(.NUM_REQ(3), .ADDR_W(32), .MDATA_W(13), .MAX_OUT(2)) dut_b (
      .clk(clk), .reset(reset), .afu_en(1'b1),
      .req_valid(b_req_valid), .req_addr(b_req_addr), .req_grant(b_req_grant),
      .tx_almostfull(1'b0), .tx_rdvalid(b_tx_rdvalid),
      .tx_addr(b_tx_addr), .tx_mdata(b_tx_mdata),
      .rx_rdvalid(b_rx_rdvalid), .rx_mdata(b_rx_mdata),
      .rsp_valid(b_rsp_valid), .idle(b_idle), .err_tag(b_err_tag)
   );

   typedef struct {
      logic        en;
      logic [1:0]  rv;
      logic        af;
      logic        rxv;
      logic [12:0] rxm;
      logic [1:0]  g;    // expected combinational grant
      logic        txv;  // expected registered outputs after the edge
      logic [12:0] md;
      logic [1:0]  rsp;
      logic        idl;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic [1:0] rv, input logic af, input logic rxv,
                      input logic [12:0] rxm, input logic [1:0] g, input logic txv,
                      input logic [12:0] md, input logic [1:0] rsp, input logic idl,
                      input logic err);
      vec_t v;
      v.en = en; v.rv = rv; v.af = af; v.rxv = rxv; v.rxm = rxm;
      v.g = g; v.txv = txv; v.md = md; v.rsp = rsp; v.idl = idl; v.err = err;
      vecs.push_back(v);
   endtask

   initial begin
      // single requester
      add(1, 2'b01, 0, 0, 0,  2'b01, 1, 0, 2'b00, 0, 0);
      // contention: alternating from ptr=1
      add(1, 2'b11, 0, 0, 0,  2'b10, 1, 1, 2'b00, 0, 0);
      add(1, 2'b11, 0, 0, 0,  2'b01, 1, 0, 2'b00, 0, 0);
      add(1, 2'b11, 0, 0, 0,  2'b10, 1, 1, 2'b00, 0, 0);
      add(1, 2'b11, 0, 0, 0,  2'b01, 1, 0, 2'b00, 0, 0);
      add(1, 2'b11, 0, 0, 0,  2'b10, 1, 1, 2'b00, 0, 0);
      add(1, 2'b11, 0, 0, 0,  2'b01, 1, 0, 2'b00, 0, 0);   // cnt0=4
      // back-pressure: no grants, mdata holds, ptr holds at 1
      add(1, 2'b11, 1, 0, 0,  2'b00, 0, 0, 2'b00, 0, 0);
      add(1, 2'b11, 1, 0, 0,  2'b00, 0, 0, 2'b00, 0, 0);
      add(1, 2'b11, 1, 0, 0,  2'b00, 0, 0, 2'b00, 0, 0);
      add(1, 2'b11, 0, 0, 0,  2'b10, 1, 1, 2'b00, 0, 0);   // cnt1=4
      // credit limit reached on both
      add(1, 2'b11, 0, 0, 0,  2'b00, 0, 1, 2'b00, 0, 0);
      add(1, 2'b10, 0, 0, 0,  2'b00, 0, 1, 2'b00, 0, 0);
      add(1, 2'b10, 0, 1, 1,  2'b00, 0, 1, 2'b10, 0, 0);   // cnt1=3
      add(1, 2'b10, 0, 0, 0,  2'b10, 1, 1, 2'b00, 0, 0);   // cnt1=4
      add(1, 2'b10, 0, 0, 0,  2'b00, 0, 1, 2'b00, 0, 0);
      add(1, 2'b10, 0, 1, 1,  2'b00, 0, 1, 2'b10, 0, 0);   // cnt1=3
      add(1, 2'b10, 0, 1, 1,  2'b10, 1, 1, 2'b10, 0, 0);   // grant+rsp: cnt1=3
      add(1, 2'b10, 0, 0, 0,  2'b10, 1, 1, 2'b00, 0, 0);   // cnt1=4
      add(1, 2'b10, 0, 0, 0,  2'b00, 0, 1, 2'b00, 0, 0);
      add(1, 2'b01, 0, 1, 0,  2'b00, 0, 1, 2'b01, 0, 0);   // cnt0=3
      add(1, 2'b01, 0, 0, 0,  2'b01, 1, 0, 2'b00, 0, 0);   // cnt0=4, ptr=1
      // afu_en low: no grants, ptr forced to 0, responses drain
      add(0, 2'b11, 0, 1, 0,  2'b00, 0, 0, 2'b01, 0, 0);
      add(0, 2'b11, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0, 0);
      add(0, 2'b00, 0, 1, 0,  2'b00, 0, 0, 2'b01, 0, 0);
      add(0, 2'b00, 0, 1, 0,  2'b00, 0, 0, 2'b01, 0, 0);
      add(0, 2'b00, 0, 1, 0,  2'b00, 0, 0, 2'b01, 0, 0);   // cnt0=0
      add(0, 2'b00, 0, 1, 1,  2'b00, 0, 0, 2'b10, 0, 0);
      add(0, 2'b00, 0, 1, 1,  2'b00, 0, 0, 2'b10, 0, 0);
      add(0, 2'b00, 0, 1, 1,  2'b00, 0, 0, 2'b10, 0, 0);
      add(0, 2'b00, 0, 1, 1,  2'b00, 0, 0, 2'b10, 1, 0);   // idle
      // re-enable: ptr restarted at 0
      add(1, 2'b11, 0, 0, 0,  2'b01, 1, 0, 2'b00, 0, 0);
      add(1, 2'b00, 0, 1, 0,  2'b00, 0, 0, 2'b01, 1, 0);
      // response to a zero counter: sticky error
      add(1, 2'b00, 0, 1, 1,  2'b00, 0, 0, 2'b10, 1, 1);
      add(1, 2'b00, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1, 1);

      reset = 1'b1;
      afu_en = 1'b0; req_valid = '0; tx_almostfull = 1'b0;
      rx_rdvalid = 1'b0; rx_mdata = '0;
      req_addr = {32'h0000_0200, 32'h0000_0100};
      b_req_valid = '0; b_rx_rdvalid = 1'b0; b_rx_mdata = '0;
      b_req_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};

      repeat (2) @(posedge clk);
      #1;
      check("reset tx_rdvalid", 64'(tx_rdvalid), 64'd0);
      check("reset tx_addr",    64'(tx_addr),    64'd0);
      check("reset tx_mdata",   64'(tx_mdata),   64'd0);
      check("reset rsp_valid",  64'(rsp_valid),  64'd0);
      check("reset idle",       64'(idle),       64'd1);
      check("reset err_tag",    64'(err_tag),    64'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         afu_en = vecs[i].en; req_valid = vecs[i].rv; tx_almostfull = vecs[i].af;
         rx_rdvalid = vecs[i].rxv; rx_mdata = vecs[i].rxm;
         #1;
         check($sformatf("v%0d req_grant", i), 64'(req_grant), 64'(vecs[i].g));
         @(posedge clk);
         #1;
         check($sformatf("v%0d tx_rdvalid", i), 64'(tx_rdvalid), 64'(vecs[i].txv));
         check($sformatf("v%0d tx_mdata", i),   64'(tx_mdata),   64'(vecs[i].md));
         check($sformatf("v%0d rsp_valid", i),  64'(rsp_valid),  64'(vecs[i].rsp));
         check($sformatf("v%0d idle", i),       64'(idle),       64'(vecs[i].idl));
         check($sformatf("v%0d err_tag", i),    64'(err_tag),    64'(vecs[i].err));
         if (vecs[i].txv)
            check($sformatf("v%0d tx_addr", i), 64'(tx_addr),
                  (vecs[i].md == 13'd0) ? 64'h100 : 64'h200);
      end

      // asynchronous reset pulse mid-cycle with traffic in flight (ptr=1 here)
      @(negedge clk);
      afu_en = 1'b1; req_valid = 2'b11; rx_rdvalid = 1'b0;
      #1;
      check("pre-reset grant", 64'(req_grant), 64'b10);
      @(posedge clk);
      #1;
      check("pre-reset tx_rdvalid", 64'(tx_rdvalid), 64'd1);
      check("pre-reset tx_addr",    64'(tx_addr),    64'h200);
      #2;
      reset = 1'b1;
      #1;
      check("async tx_rdvalid", 64'(tx_rdvalid), 64'd0);
      check("async tx_addr",    64'(tx_addr),    64'd0);
      check("async tx_mdata",   64'(tx_mdata),   64'd0);
      check("async err_tag",    64'(err_tag),    64'd0);
      check("async idle",       64'(idle),       64'd1);
      check("async grant ptr0", 64'(req_grant),  64'b01);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 2'b00; rx_rdvalid = 1'b1; rx_mdata = 13'd1;
      @(posedge clk);
      #1;
      check("post-reset rsp_valid", 64'(rsp_valid), 64'b10);
      check("post-reset err_tag",   64'(err_tag),   64'd1);
      check("post-reset idle",      64'(idle),      64'd1);
      @(negedge clk);
      rx_rdvalid = 1'b0;

      // three-requester wrap: 0, 2, 0
      b_req_valid = 3'b101;
      #1;
      check("b grant0", 64'(b_req_grant), 64'b001);
      @(posedge clk); #1;
      check("b mdata0", 64'(b_tx_mdata), 64'd0);
      check("b addr0",  64'(b_tx_addr),  64'h1000);
      @(negedge clk); #1;
      check("b grant1", 64'(b_req_grant), 64'b100);
      @(posedge clk); #1;
      check("b mdata1", 64'(b_tx_mdata), 64'd2);
      check("b addr1",  64'(b_tx_addr),  64'h3000);
      check("b idle",   64'(b_idle),     64'd0);
      @(negedge clk); #1;
      check("b grant2", 64'(b_req_grant), 64'b001);
      @(posedge clk); #1;
      check("b mdata2", 64'(b_tx_mdata), 64'd0);

      // bad tag 3 on a 3-requester instance
      @(negedge clk);
      b_req_valid = 3'b000; b_rx_rdvalid = 1'b1; b_rx_mdata = 13'd3;
      @(posedge clk); #1;
      check("b badtag rsp_valid", 64'(b_rsp_valid), 64'b000);
      check("b badtag err_tag",   64'(b_err_tag),   64'd1);
      @(negedge clk);
      b_rx_rdvalid = 1'b0;
      @(posedge clk); #1;
      check("b err sticky", 64'(b_err_tag), 64'd1);
      check("b rsp quiet",  64'(b_rsp_valid), 64'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
